// File: rtl/laser_trigger_sequencer_if.sv
// Control, trigger and status signals of the laser trigger sequencer.
// The master side (b2tt glue / slow control) drives the configuration and the
// recovered trigger/frame markers; the slave side (the sequencer) returns the
// laser pulse, busy and the counters.
interface laser_trigger_sequencer_if #(
    parameter int unsigned DELAY_WIDTH    = 16,
    parameter int unsigned PRESCALE_WIDTH = 8
);
    logic                      enable;
    logic                      sync_to_frame;
    logic [DELAY_WIDTH-1:0]    delay;
    logic [PRESCALE_WIDTH-1:0] prescale;
    logic                      trg;
    logic                      frame9;
    logic                      laser;
    logic                      busy;
    logic [31:0]               fire_count;
    logic [15:0]               dropped_count;

    modport master (
        output enable, sync_to_frame, delay, prescale, trg, frame9,
        input  laser, busy, fire_count, dropped_count
    );

    modport slave (
        input  enable, sync_to_frame, delay, prescale, trg, frame9,
        output laser, busy, fire_count, dropped_count
    );
endinterface

// File: rtl/laser_trigger_sequencer.sv
// Laser trigger sequencer: turns the b2tt recovered trigger into a laser fire
// pulse with prescale, optional frame9 alignment, programmable delay, fixed
// pulse width and holdoff. busy reports every non-idle state back to b2tt.
module laser_trigger_sequencer #(
    parameter int unsigned PULSE_CYCLES   = 8,
    parameter int unsigned HOLDOFF_CYCLES = 1282,
    parameter int unsigned DELAY_WIDTH    = 16,
    parameter int unsigned PRESCALE_WIDTH = 8
) (
    input logic                     clock,
    input logic                     reset_n,
    laser_trigger_sequencer_if.slave bus
);

    localparam int unsigned PULSE_W = $clog2(PULSE_CYCLES + 1);
    localparam int unsigned HOLD_W  = $clog2(HOLDOFF_CYCLES + 1);
    localparam int unsigned W1      = (DELAY_WIDTH > HOLD_W) ? DELAY_WIDTH : HOLD_W;
    localparam int unsigned CNT_W   = (W1 > PULSE_W) ? W1 : PULSE_W;

    localparam logic [CNT_W-1:0] PULSE_LAST = CNT_W'(PULSE_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(HOLDOFF_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_FRAME,
        S_DELAY,
        S_FIRE,
        S_HOLDOFF
    } state_t;

    state_t                    state_q, state_d;

    logic                      trg_cur_q, trg_prev_q;
    logic                      frm_cur_q, frm_prev_q;
    logic                      trg_edge, frm_edge;
    logic                      accept;

    logic [PRESCALE_WIDTH-1:0] presc_cnt_q, presc_cnt_d;
    logic [PRESCALE_WIDTH-1:0] presc_last;
    logic [DELAY_WIDTH-1:0]    delay_q, delay_d;
    logic [CNT_W-1:0]          cnt_q, cnt_d;

    logic                      laser_q, laser_d;
    logic                      busy_q, busy_d;
    logic [31:0]               fire_count_q, fire_count_d;
    logic [15:0]               dropped_count_q, dropped_count_d;

    // Both histories are registered, so an input already high when reset is
    // released produces its edge one cycle later, never in the first cycle.
    assign trg_edge = trg_cur_q & ~trg_prev_q;
    assign frm_edge = frm_cur_q & ~frm_prev_q;

    // prescale of 0 behaves like 1: every trigger is accepted
    assign presc_last = (bus.prescale == '0) ? '0 : bus.prescale - PRESCALE_WIDTH'(1);

    assign accept = (state_q == S_IDLE) && bus.enable && trg_edge &&
                    (presc_cnt_q == presc_last);

    // Input history registers for trg and frame9 edge detection
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            trg_cur_q  <= 1'b0;
            trg_prev_q <= 1'b0;
            frm_cur_q  <= 1'b0;
            frm_prev_q <= 1'b0;
        end else begin
            trg_cur_q  <= bus.trg;
            trg_prev_q <= trg_cur_q;
            frm_cur_q  <= bus.frame9;
            frm_prev_q <= frm_cur_q;
        end
    end

    // State register with registered laser and busy outputs
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            laser_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            laser_q <= laser_d;
            busy_q  <= busy_d;
        end
    end

    // Next-state logic; enable only aborts the states before the pulse starts
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    state_d = bus.sync_to_frame ? S_WAIT_FRAME : S_DELAY;
                end
            end
            S_WAIT_FRAME: begin
                if (!bus.enable) begin
                    state_d = S_IDLE;
                end else if (frm_edge) begin
                    state_d = S_DELAY;
                end
            end
            S_DELAY: begin
                if (!bus.enable) begin
                    state_d = S_IDLE;
                end else if (cnt_q == CNT_W'(delay_q)) begin
                    state_d = S_FIRE;
                end
            end
            S_FIRE: begin
                if (cnt_q == PULSE_LAST) begin
                    state_d = S_HOLDOFF;
                end
            end
            S_HOLDOFF: begin
                if (cnt_q == HOLD_LAST) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Output decode from the next state so laser and busy come from flops
    always_comb begin
        laser_d = (state_d == S_FIRE);
        busy_d  = (state_d != S_IDLE);
    end

    // Datapath next values: phase counter, prescale, latched delay, counters
    always_comb begin
        cnt_d           = cnt_q + CNT_W'(1);
        presc_cnt_d     = presc_cnt_q;
        delay_d         = delay_q;
        fire_count_d    = fire_count_q;
        dropped_count_d = dropped_count_q;

        // the phase counter restarts on every state change and idles at zero
        if ((state_d != state_q) || (state_q == S_IDLE) || (state_q == S_WAIT_FRAME)) begin
            cnt_d = '0;
        end

        if (!bus.enable) begin
            presc_cnt_d = '0;
        end else if ((state_q == S_IDLE) && trg_edge) begin
            presc_cnt_d = accept ? '0 : presc_cnt_q + PRESCALE_WIDTH'(1);
        end

        if (accept) begin
            delay_d = bus.delay;
        end

        if ((state_d == S_FIRE) && (state_q != S_FIRE)) begin
            fire_count_d = fire_count_q + 32'd1;
        end

        if ((state_q != S_IDLE) && trg_edge && (dropped_count_q != '1)) begin
            dropped_count_d = dropped_count_q + 16'd1;
        end
    end

    // Datapath registers
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q           <= '0;
            presc_cnt_q     <= '0;
            delay_q         <= '0;
            fire_count_q    <= '0;
            dropped_count_q <= '0;
        end else begin
            cnt_q           <= cnt_d;
            presc_cnt_q     <= presc_cnt_d;
            delay_q         <= delay_d;
            fire_count_q    <= fire_count_d;
            dropped_count_q <= dropped_count_d;
        end
    end

    assign bus.laser         = laser_q;
    assign bus.busy          = busy_q;
    assign bus.fire_count    = fire_count_q;
    assign bus.dropped_count = dropped_count_q;

    laser_implies_busy_a: assert property (
        @(posedge clock) disable iff (!reset_n) laser_q |-> busy_q
    );

    busy_tracks_state_a: assert property (
        @(posedge clock) disable iff (!reset_n) busy_q == (state_q != S_IDLE)
    );

endmodule

// File: tb/tb_laser_trigger_sequencer.sv
// Scoreboard bench for laser_trigger_sequencer. Stimulus tasks feed an
// event-level reference model that predicts laser rise cycles (queued), the
// busy window and the counters; a negedge monitor checks the DUT against it.
module tb_laser_trigger_sequencer;

    localparam int unsigned P  = 8;
    localparam int unsigned H  = 1282;
    localparam int unsigned DW = 16;
    localparam int unsigned PW = 8;

    logic clock   = 1'b0;
    logic reset_n = 1'b0;

    laser_trigger_sequencer_if #(.DELAY_WIDTH(DW), .PRESCALE_WIDTH(PW)) bus ();

    laser_trigger_sequencer #(
        .PULSE_CYCLES   (P),
        .HOLDOFF_CYCLES (H),
        .DELAY_WIDTH    (DW),
        .PRESCALE_WIDTH (PW)
    ) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus.slave)
    );

    always #5 clock = ~clock;

    // index of the most recent rising edge
    int unsigned cycle = 0;
    always @(posedge clock) cycle <= cycle + 1;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input longint unsigned act, input longint unsigned exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cycle);
        end
    endtask

    // ---------------- reference model ----------------
    bit          en = 1'b0;
    bit          sync_cfg = 1'b0;
    int unsigned presc_cfg = 1;
    int unsigned dly_cfg = 0;

    int unsigned m_from = 1;          // first edge index after which busy is high
    int unsigned m_until = 0;         // last edge index after which busy is high
    bit          m_pending = 1'b0;    // accepted, waiting for frame9
    int unsigned m_accept_edge = 0;
    int unsigned m_dly_l = 0;
    int unsigned m_presc_cnt = 0;
    logic [31:0] m_fires = '0;
    logic [15:0] m_dropped = '0;
    int unsigned exp_q[$];

    // trg sampled high first at edge n
    function automatic void model_trg(input int unsigned n);
        int unsigned every;
        if (n >= m_from && n <= m_until) begin
            if (m_dropped != 16'hFFFF) m_dropped++;
            return;
        end
        if (!en) return;
        every = (presc_cfg == 0) ? 1 : presc_cfg;
        m_presc_cnt++;
        if (m_presc_cnt < every) return;
        m_presc_cnt = 0;
        m_from  = n + 1;
        m_dly_l = dly_cfg;
        if (sync_cfg) begin
            m_pending     = 1'b1;
            m_accept_edge = n + 1;
            m_until       = 32'hFFFF_FFFF;
        end else begin
            exp_q.push_back(n + 2 + m_dly_l);
            m_until = n + 1 + m_dly_l + P + H;
            m_fires++;
        end
    endfunction

    // frame9 sampled high first at edge m
    function automatic void model_frame(input int unsigned m);
        if (m_pending && m >= m_accept_edge) begin
            exp_q.push_back(m + 2 + m_dly_l);
            m_until   = m + 1 + m_dly_l + P + H;
            m_fires++;
            m_pending = 1'b0;
        end
    endfunction

    function automatic void model_reset();
        exp_q.delete();
        m_from      = 1;
        m_until     = 0;
        m_pending   = 1'b0;
        m_presc_cnt = 0;
        m_fires     = '0;
        m_dropped   = '0;
    endfunction

    // ---------------- monitor ----------------
    logic        laser_prev = 1'b0;
    int unsigned run = 0;

    always @(negedge clock) begin
        if (!reset_n) begin
            laser_prev = 1'b0;
            run        = 0;
        end else begin
            if (bus.laser && !laser_prev) begin
                check("laser_expected", (exp_q.size() != 0), 1);
                if (exp_q.size() != 0) check("laser_rise_cycle", cycle, exp_q.pop_front());
                run = 1;
            end else if (bus.laser) begin
                run++;
            end else if (laser_prev) begin
                check("pulse_width", run, P);
            end
            check("busy", bus.busy, (cycle >= m_from && cycle <= m_until));
            laser_prev = bus.laser;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic step();
        @(negedge clock);
        #1;
    endtask

    task automatic wait_cycles(input int unsigned n);
        repeat (n) step();
    endtask

    task automatic set_cfg(input int unsigned p, input int unsigned d, input bit s);
        presc_cfg = p;  dly_cfg = d;  sync_cfg = s;
        bus.prescale      = PW'(p);
        bus.delay         = DW'(d);
        bus.sync_to_frame = s;
    endtask

    task automatic set_enable(input bit v);
        en = v;
        bus.enable = v;
        if (!v) begin
            m_presc_cnt = 0;
            if (cycle + 1 >= m_from) begin
                if (m_pending) begin
                    m_pending = 1'b0;
                    m_until   = cycle;
                end else if (exp_q.size() != 0 && exp_q[$] > cycle + 1) begin
                    void'(exp_q.pop_back());
                    m_fires--;
                    m_until = cycle;
                end
            end
        end
    endtask

    task automatic trg_pulse(input int unsigned h);
        bus.trg = 1'b1;
        model_trg(cycle + 1);
        wait_cycles(h);
        bus.trg = 1'b0;
        step();
    endtask

    task automatic frame_pulse(input int unsigned h);
        bus.frame9 = 1'b1;
        model_frame(cycle + 1);
        wait_cycles(h);
        bus.frame9 = 1'b0;
        step();
    endtask

    task automatic both_pulse();
        bus.trg    = 1'b1;
        bus.frame9 = 1'b1;
        model_trg(cycle + 1);
        model_frame(cycle + 1);
        step();
        bus.trg    = 1'b0;
        bus.frame9 = 1'b0;
        step();
    endtask

    task automatic wait_idle();
        int unsigned k = 0;
        while ((m_pending || cycle <= m_until || exp_q.size() != 0) && k < 6000) begin
            step();
            k++;
        end
        check("idle_within_budget", (k < 6000), 1);
        step();
    endtask

    task automatic check_counts(input string tag);
        check({tag, "_fire_count"}, bus.fire_count, m_fires);
        check({tag, "_dropped_count"}, bus.dropped_count, m_dropped);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- main sequence ----------------
    initial begin
        bus.enable = 1'b0;  bus.sync_to_frame = 1'b0;
        bus.delay = '0;     bus.prescale = '0;
        bus.trg = 1'b0;     bus.frame9 = 1'b0;
        repeat (3) @(negedge clock);
        check("reset_laser", bus.laser, 0);
        check("reset_busy", bus.busy, 0);
        check("reset_fire_count", bus.fire_count, 0);
        check("reset_dropped_count", bus.dropped_count, 0);
        #1 reset_n = 1'b1;
        wait_cycles(3);

        // single trigger, prescale 1, delay 5
        set_cfg(1, 5, 1'b0);
        set_enable(1'b1);
        step();
        trg_pulse(3);
        wait_idle();
        check_counts("t1");

        // prescale 4, eight widely spaced triggers
        set_cfg(4, 5, 1'b0);
        for (int i = 0; i < 8; i++) begin
            trg_pulse(1);
            wait_cycles(1998);
        end
        wait_idle();
        check_counts("t2");

        // frame alignment, coincident frame9 ignored
        set_cfg(1, 0, 1'b1);
        both_pulse();
        wait_cycles(98);
        frame_pulse(2);
        wait_idle();
        check_counts("t3");

        // triggers while busy are dropped
        set_cfg(1, 3, 1'b0);
        for (int i = 0; i < 3; i++) begin
            trg_pulse(1);
            wait_cycles(8);
        end
        wait_idle();
        check_counts("t4a");

        // dropped_count saturation from a near-full value
        force dut.dropped_count_q = 16'hFFFD;
        step();
        release dut.dropped_count_q;
        m_dropped = 16'hFFFD;
        for (int i = 0; i < 5; i++) begin
            trg_pulse(1);
            wait_cycles(8);
        end
        wait_idle();
        check_counts("t4b");

        // fire_count wrap from all ones
        force dut.fire_count_q = 32'hFFFF_FFFF;
        step();
        release dut.fire_count_q;
        m_fires = 32'hFFFF_FFFF;
        trg_pulse(1);
        wait_idle();
        check_counts("t4c");

        // enable dropped during DELAY aborts without a pulse
        set_cfg(1, 50, 1'b0);
        trg_pulse(1);
        wait_cycles(10);
        set_enable(1'b0);
        step();
        check("busy_after_abort", bus.busy, 0);
        wait_cycles(3);
        set_enable(1'b1);
        wait_idle();
        check_counts("t5a");

        // enable dropped during FIRE: full pulse and holdoff
        set_cfg(1, 2, 1'b0);
        trg_pulse(1);
        wait_cycles(5);
        set_enable(1'b0);
        wait_idle();
        set_enable(1'b1);
        check_counts("t5b");

        // asynchronous reset in the middle of a pulse
        trg_pulse(1);
        wait_cycles(5);
        #2 reset_n = 1'b0;
        #1;
        check("async_reset_laser", bus.laser, 0);
        check("async_reset_busy", bus.busy, 0);
        check("async_reset_fire_count", bus.fire_count, 0);
        check("async_reset_dropped_count", bus.dropped_count, 0);
        model_reset();
        wait_cycles(2);
        reset_n = 1'b1;
        wait_cycles(2);
        trg_pulse(1);
        wait_idle();
        check_counts("t6");

        // randomized phases: prescale fixed per phase, delay/sync changed only while idle
        for (int ph = 0; ph < 4; ph++) begin
            set_enable(1'b0);
            step();
            set_cfg($urandom_range(0, 3), $urandom_range(0, 20), ($urandom_range(0, 3) == 0));
            set_enable(1'b1);
            step();
            for (int i = 0; i < 20; i++) begin
                if (!m_pending && cycle > m_until)
                    set_cfg(presc_cfg, $urandom_range(0, 20), ($urandom_range(0, 3) == 0));
                if ($urandom_range(0, 9) < 7) trg_pulse($urandom_range(1, 3));
                else                          frame_pulse($urandom_range(1, 2));
                wait_cycles($urandom_range(0, 400));
            end
            if (m_pending) frame_pulse(1);
            wait_idle();
            check_counts("random");
        end

        check("scoreboard_drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
